haar_evaluator: RTL and testbench

HAAR_EVALUATOR -- requirements
Module: haar_evaluator

---
 rtl/face_pkg.sv | 21 ++
 rtl/integral_ram.sv | 34 +++
 rtl/haar_evaluator.sv | 150 +++++++++++++++
 tb/tb_haar_evaluator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/face_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | face_pkg : shared window geometry, index type and evaluator states  |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package face_pkg;
   localparam int WIN   = 20;
   localparam int WIN_N = 400;

   typedef logic [8:0] idx_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCUM  = 3'd1,
      EVAL_A = 3'd2,
      EVAL_B = 3'd3,
      EVAL_C = 3'd4,
      DONE_S = 3'd5
   } state_t;
endpackage
`default_nettype wire

// File: rtl/integral_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | integral_ram : single-port accumulate-on-write store, sync read     |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module integral_ram
   import face_pkg::*;
#(
   parameter int DEPTH = WIN_N
) (
   input  logic        clk,
   input  logic        we,
   input  logic        keep,
   input  logic        re,
   input  idx_t        addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);
   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // A write either adds to the stored word or, for a first touch, replaces it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= (keep ? mem_q[addr] : 32'd0) + wdata;
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;
endmodule
`default_nettype wire

// File: rtl/haar_evaluator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | haar_evaluator : accumulates a window, scores a two-rectangle Haar  |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module haar_evaluator #(
   parameter int                 WIN       = 20,
   parameter int                 ROW_SPLIT = 10,
   parameter logic signed [31:0] THRESH    = 32'sd0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        START,
   input  logic        IN_VALID,
   input  logic [8:0]  INDX,
   input  logic [31:0] DATA,
   input  logic        IN_LAST,
   output logic        BUSY,
   output logic        DONE,
   output logic        FACE,
   output logic [31:0] SCORE,
   output logic        ERR
);
   import face_pkg::*;

   localparam int         N      = WIN * WIN;
   localparam logic [9:0] N_L    = 10'(N);
   localparam idx_t       ADDR_U = 9'(ROW_SPLIT * WIN - 1);
   localparam idx_t       ADDR_T = 9'(N - 1);

   state_t       state_q, state_d;
   logic [N-1:0] written_q, written_d;
   logic         rd_wr_q, rd_wr_d;
   logic [31:0]  u_q, u_d;
   logic [31:0]  score_q, score_d;
   logic         done_q, done_d;
   logic         face_q, face_d;
   logic         err_q, err_d;

   logic         ram_we, ram_re, in_range;
   idx_t         ram_addr;
   logic [31:0]  ram_rdata, rd_val;

   assign in_range = ({1'b0, INDX} < N_L);
   // Entries never written since START read as zero regardless of stale RAM content.
   assign rd_val   = rd_wr_q ? ram_rdata : 32'd0;

   always_comb begin
      state_d   = state_q;
      written_d = written_q;
      rd_wr_d   = rd_wr_q;
      u_d       = u_q;
      score_d   = score_q;
      done_d    = done_q;
      face_d    = face_q;
      err_d     = err_q;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = INDX;

      case (state_q)
         IDLE, DONE_S: begin
            if (START) begin
               written_d = '0;
               err_d     = 1'b0;
               done_d    = 1'b0;
               state_d   = ACCUM;
            end
         end
         ACCUM: begin
            if (IN_VALID) begin
               if (in_range) begin
                  ram_we          = 1'b1;
                  written_d[INDX] = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               if (IN_LAST) begin
                  state_d = EVAL_A;
               end
            end
         end
         EVAL_A: begin
            ram_re   = 1'b1;
            ram_addr = ADDR_U;
            rd_wr_d  = written_q[ADDR_U];
            state_d  = EVAL_B;
         end
         EVAL_B: begin
            ram_re   = 1'b1;
            ram_addr = ADDR_T;
            rd_wr_d  = written_q[ADDR_T];
            u_d      = rd_val;
            state_d  = EVAL_C;
         end
         EVAL_C: begin
            score_d = (u_q << 1) - rd_val;
            face_d  = ($signed(score_d) > THRESH);
            done_d  = 1'b1;
            state_d = DONE_S;
         end
         default: state_d = IDLE;
      endcase

      if (RESET) begin
         ram_we = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         written_q <= '0;
         rd_wr_q   <= 1'b0;
         u_q       <= 32'd0;
         score_q   <= 32'd0;
         done_q    <= 1'b0;
         face_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         written_q <= written_d;
         rd_wr_q   <= rd_wr_d;
         u_q       <= u_d;
         score_q   <= score_d;
         done_q    <= done_d;
         face_q    <= face_d;
         err_q     <= err_d;
      end
   end

   integral_ram #(
      .DEPTH (N)
   ) u_ram (
      .clk   (CLK),
      .we    (ram_we),
      .keep  (written_q[INDX]),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (DATA),
      .rdata (ram_rdata)
   );

   assign BUSY  = (state_q != IDLE);
   assign DONE  = done_q;
   assign FACE  = face_q;
   assign SCORE = score_q;
   assign ERR   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_haar_evaluator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_haar_evaluator : directed windows against a behavioural model    |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_haar_evaluator;
   logic        clk = 1'b0;
   logic        rst, start, in_valid, in_last;
   logic [8:0]  indx;
   logic [31:0] data;
   logic        busy, done, face, err;
   logic [31:0] score;

   int n_vec  = 0;
   int n_fail = 0;
   bit chk_en = 0;

   // Behavioural model: window contents plus the observable outputs.
   int m_buf [400];
   bit m_wr  [400];
   int m_mode;          // 0 idle, 1 collecting, 2 evaluating, 3 result held
   int m_left;
   bit m_done, m_face, m_err;
   int m_score;

   haar_evaluator dut (
      .CLK      (clk),
      .RESET    (rst),
      .START    (start),
      .IN_VALID (in_valid),
      .INDX     (indx),
      .DATA     (data),
      .IN_LAST  (in_last),
      .BUSY     (busy),
      .DONE     (done),
      .FACE     (face),
      .SCORE    (score),
      .ERR      (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                  name, $signed(act), act, $signed(exp), exp, $time);
      end
   endtask

   function automatic int rd(input int i);
      return m_wr[i] ? m_buf[i] : 0;
   endfunction

   task automatic new_window();
      for (int i = 0; i < 400; i++) m_wr[i] = 0;
      m_err  = 0;
      m_done = 0;
      m_mode = 1;
   endtask

   task automatic model_edge(input bit s, input bit v, input int ix, input int d,
                             input bit l, input bit r);
      if (r) begin
         m_mode = 0; m_done = 0; m_face = 0; m_score = 0; m_err = 0;
         for (int i = 0; i < 400; i++) m_wr[i] = 0;
         return;
      end
      case (m_mode)
         0, 3: if (s) new_window();
         1: if (v) begin
               if (ix < 400) begin
                  m_buf[ix] = rd(ix) + d;
                  m_wr[ix]  = 1;
               end else begin
                  m_err = 1;
               end
               if (l) begin
                  m_mode = 2;
                  m_left = 3;
               end
            end
         default: begin
            m_left--;
            if (m_left == 0) begin
               m_score = 2 * rd(199) - rd(399);
               m_face  = (m_score > 0);
               m_done  = 1;
               m_mode  = 3;
            end
         end
      endcase
   endtask

   task automatic step(input bit s, input bit v, input int ix, input int d,
                       input bit l, input bit r);
      start = s; in_valid = v; indx = 9'(ix); data = d; in_last = l; rst = r;
      @(posedge clk);
      model_edge(s, v, ix, d, l, r);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",  {31'd0, busy}, {31'd0, m_mode != 0});
         chk("done",  {31'd0, done}, {31'd0, m_done});
         chk("face",  {31'd0, face}, {31'd0, m_face});
         chk("err",   {31'd0, err},  {31'd0, m_err});
         chk("score", score, m_score);
      end
   end

   initial begin
      m_mode = 0; m_done = 0; m_face = 0; m_err = 0; m_score = 0; m_left = 0;
      for (int i = 0; i < 400; i++) begin m_wr[i] = 0; m_buf[i] = 0; end

      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk_en = 1;
      chk("reset_busy", {31'd0, busy}, 32'd0);

      // Beats while idle must not accumulate; START with a coincident beat drops the beat.
      step(0, 1, 199, 50, 0, 0);
      step(0, 1, 399, 50, 1, 0);
      step(1, 1, 199, 77, 0, 0);
      chk("start_busy", {31'd0, busy}, 32'd1);

      // Window A, with a stray START in the middle of collection.
      for (int i = 0; i < 400; i++) step(i == 100, 1, i, (i < 200) ? 2 : 1, i == 399, 0);
      idle(2);
      chk("lat_a_early", {31'd0, done}, 32'd0);
      idle(1);
      chk("lat_a_done",  {31'd0, done}, 32'd1);
      chk("score_a",     score, 32'd3);
      chk("face_a",      {31'd0, face}, 32'd1);
      idle(3);
      chk("hold_a",      score, 32'd3);

      // Window B: repeated index sums.
      step(1, 0, 0, 0, 0, 0);
      chk("done_drop",   {31'd0, done}, 32'd0);
      step(0, 1, 199, 5, 0, 0);
      step(0, 1, 199, 7, 0, 0);
      step(0, 1, 399, 3, 1, 0);
      idle(4);
      chk("score_b",     score, 32'd21);
      chk("face_b",      {31'd0, face}, 32'd1);

      // Window C: old contents must read as cleared.
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 399, 100, 1, 0);
      idle(4);
      chk("score_c",     score, -32'sd100);
      chk("face_c",      {31'd0, face}, 32'd0);

      // Window D: out-of-range index raises sticky ERR.
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 199, 4, 0, 0);
      step(0, 1, 450, 9, 0, 0);
      chk("err_set",     {31'd0, err}, 32'd1);
      step(0, 1, 399, 1, 1, 0);
      idle(4);
      chk("err_hold",    {31'd0, err}, 32'd1);
      chk("score_d",     score, 32'd7);
      step(1, 0, 0, 0, 0, 0);
      chk("err_clear",   {31'd0, err}, 32'd0);

      // Reset mid-collection, with START and a beat in the same cycle.
      step(0, 1, 199, 11, 0, 0);
      step(1, 1, 399, 11, 1, 1);
      chk("rst_acc_busy",  {31'd0, busy}, 32'd0);
      chk("rst_acc_score", score, 32'd0);

      // Reset during the second evaluation cycle.
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 199, 30, 0, 0);
      step(0, 1, 399, 1, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rst_eval_busy", {31'd0, busy}, 32'd0);
      chk("rst_eval_done", {31'd0, done}, 32'd0);
      idle(3);
      chk("rst_eval_quiet", {31'd0, done}, 32'd0);

      // Recovery windows: negative values, then a zero score at the threshold.
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 199, -3, 0, 0);
      step(0, 1, 399, -10, 1, 0);
      idle(4);
      chk("score_e",     score, 32'd4);
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 199, 1, 0, 0);
      step(0, 1, 399, 2, 1, 0);
      idle(4);
      chk("score_f",     score, 32'd0);
      chk("face_f",      {31'd0, face}, 32'd0);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
